// File: rtl/mcif_rd_pkg.sv
// Shared helpers for the MCIF read ingress arbiter.
// client_w : width of a client index for a given client count (at least 1)
// beats_w  : width of a beat count or outstanding-beat counter for a limit register of os_w bits.
//            It is one bit wider because the counter can reach limit+1 == 2**os_w.
package mcif_rd_pkg;

  function automatic int unsigned client_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned beats_w(input int unsigned os_w);
    return os_w + 1;
  endfunction

endpackage

// File: rtl/mcif_rd_wrr_pick.sv
// Rotating priority encoder: returns the lowest-index set bit of cand at or after start,
// wrapping modulo NUM_CLIENTS (not modulo 2**CLIENT_W).
// Ports:
//   cand  - candidate vector, one bit per client
//   start - first index to consider
//   found - at least one candidate present
//   idx   - selected client index (0 when found=0)
module mcif_rd_wrr_pick #(
  parameter int unsigned NUM_CLIENTS = 8,
  parameter int unsigned CLIENT_W    = 3
) (
  input  logic [NUM_CLIENTS-1:0] cand,
  input  logic [CLIENT_W-1:0]    start,
  output logic                   found,
  output logic [CLIENT_W-1:0]    idx
);

  always_comb begin
    int unsigned j;
    logic [CLIENT_W-1:0] jj;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      j  = (32'(start) + k) % NUM_CLIENTS;
      jj = CLIENT_W'(j);
      if (!found && cand[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/mcif_read_ig_wrr_arb.sv
// MCIF read ingress arbiter: weighted round-robin over NUM_CLIENTS split DMA read requests,
// gated by an outstanding-beat credit limit, driving a single registered AXI AR stage.
// Ports:
//   nvdla_core_clk / nvdla_core_rst  - clock, synchronous active-high reset
//   req_valid / req_ready            - per-client handshake (ready only in the granting cycle)
//   req_addr / req_len               - flattened per-client address and arlen
//   reg2dp_rd_weight                 - flattened per-client weights (w -> up to w+1 grants/turn)
//   reg2dp_rd_os_cnt                 - outstanding beat limit minus one
//   eg2ig_axi_vld                    - one read beat retired by egress
//   mcif2noc_axi_ar_*                - registered AXI AR channel
module mcif_read_ig_wrr_arb
  import mcif_rd_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 8,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned ID_W        = 8,
  parameter int unsigned WEIGHT_W    = 8,
  parameter int unsigned OS_W        = 8
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*LEN_W-1:0]  req_len,
  input  logic [NUM_CLIENTS*WEIGHT_W-1:0] reg2dp_rd_weight,
  input  logic [OS_W-1:0]               reg2dp_rd_os_cnt,
  input  logic                          eg2ig_axi_vld,
  output logic                          mcif2noc_axi_ar_arvalid,
  input  logic                          mcif2noc_axi_ar_arready,
  output logic [ID_W-1:0]               mcif2noc_axi_ar_arid,
  output logic [LEN_W-1:0]              mcif2noc_axi_ar_arlen,
  output logic [ADDR_W-1:0]             mcif2noc_axi_ar_araddr
);

  localparam int unsigned CLIENT_W = client_w(NUM_CLIENTS);
  localparam int unsigned BEATS_W  = beats_w(OS_W);
  localparam int unsigned SUM_W    = BEATS_W + 1;

  // AR payload; widths follow this instance's parameters.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } ar_payload_t;

  // State
  logic                arvalid_q, arvalid_d;
  ar_payload_t         ar_q, ar_d;
  logic [CLIENT_W-1:0] owner_q, owner_d;
  logic                has_owner_q, has_owner_d;
  logic [WEIGHT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [BEATS_W-1:0]  os_cnt_q, os_cnt_d;

  // Unpacked request views
  logic [ADDR_W-1:0]   addr_arr   [NUM_CLIENTS];
  logic [LEN_W-1:0]    len_arr    [NUM_CLIENTS];
  logic [WEIGHT_W-1:0] weight_arr [NUM_CLIENTS];
  logic [BEATS_W-1:0]  beats_arr  [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] cand;
  logic [SUM_W-1:0]    limit_ext;

  logic                load;
  logic                owner_keep;
  logic [CLIENT_W-1:0] pick_start;
  logic                pick_found;
  logic [CLIENT_W-1:0] pick_idx;
  logic                grant_vld;
  logic [CLIENT_W-1:0] grant_idx;
  logic                grant_load;
  logic [SUM_W-1:0]    os_sum;
  logic                underflow;

  assign load      = !arvalid_q || mcif2noc_axi_ar_arready;
  assign limit_ext = SUM_W'(reg2dp_rd_os_cnt) + SUM_W'(1);

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      addr_arr[i]   = req_addr[i*ADDR_W +: ADDR_W];
      len_arr[i]    = req_len[i*LEN_W +: LEN_W];
      weight_arr[i] = reg2dp_rd_weight[i*WEIGHT_W +: WEIGHT_W];
      beats_arr[i]  = BEATS_W'(len_arr[i]) + BEATS_W'(1);
      cand[i]       = req_valid[i] &&
                      ((SUM_W'(os_cnt_q) + SUM_W'(beats_arr[i])) <= limit_ext);
    end
  end

  // Before the first grant after reset there is no owner, so the search starts at the
  // pointer itself (client 0) instead of the slot after it.
  always_comb begin
    if (!has_owner_q) begin
      pick_start = owner_q;
    end else if (owner_q == CLIENT_W'(NUM_CLIENTS - 1)) begin
      pick_start = '0;
    end else begin
      pick_start = owner_q + 1'b1;
    end
  end

  mcif_rd_wrr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .CLIENT_W    (CLIENT_W)
  ) u_pick (
    .cand  (cand),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_keep = has_owner_q && cand[owner_q] && (burst_cnt_q < weight_arr[owner_q]);

  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = owner_q;
    owner_d     = owner_q;
    has_owner_d = has_owner_q;
    burst_cnt_d = burst_cnt_q;
    if (owner_keep) begin
      grant_vld = 1'b1;
      grant_idx = owner_q;
    end else if (pick_found) begin
      grant_vld = 1'b1;
      grant_idx = pick_idx;
    end
    if (load && grant_vld) begin
      owner_d     = grant_idx;
      has_owner_d = 1'b1;
      // A fresh turn (even back to the same client) restarts the burst count.
      burst_cnt_d = owner_keep ? burst_cnt_q + 1'b1 : '0;
    end
  end

  assign grant_load = load && grant_vld;

  always_comb begin
    req_ready = '0;
    if (!nvdla_core_rst && grant_load) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Credits are consumed at the grant edge and returned one beat per egress pulse.
  always_comb begin
    os_sum = SUM_W'(os_cnt_q);
    if (grant_load) begin
      os_sum = os_sum + SUM_W'(beats_arr[grant_idx]);
    end
    if (eg2ig_axi_vld && (os_sum != '0)) begin
      os_sum = os_sum - SUM_W'(1);
    end
    os_cnt_d = BEATS_W'(os_sum);
  end

  assign underflow = eg2ig_axi_vld && (os_cnt_q == '0) && !grant_load;

  always_comb begin
    arvalid_d = arvalid_q;
    ar_d      = ar_q;
    if (load) begin
      arvalid_d = grant_vld;
      if (grant_vld) begin
        ar_d.id   = ID_W'(grant_idx);
        ar_d.len  = len_arr[grant_idx];
        ar_d.addr = addr_arr[grant_idx];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      arvalid_q   <= 1'b0;
      ar_q        <= '0;
      owner_q     <= '0;
      has_owner_q <= 1'b0;
      burst_cnt_q <= '0;
      os_cnt_q    <= '0;
    end else begin
      arvalid_q   <= arvalid_d;
      ar_q        <= ar_d;
      owner_q     <= owner_d;
      has_owner_q <= has_owner_d;
      burst_cnt_q <= burst_cnt_d;
      os_cnt_q    <= os_cnt_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rst) begin
      assert (!underflow)
        else $error("mcif_read_ig_wrr_arb: eg2ig_axi_vld with no beats outstanding");
    end
  end

  assign mcif2noc_axi_ar_arvalid = arvalid_q;
  assign mcif2noc_axi_ar_arid    = ar_q.id;
  assign mcif2noc_axi_ar_arlen   = ar_q.len;
  assign mcif2noc_axi_ar_araddr  = ar_q.addr;

endmodule

// File: tb/tb_mcif_read_ig_wrr_arb.sv
// Directed bench for mcif_read_ig_wrr_arb: a 4-client instance for WRR, credit,
// back-pressure and reset steps, and a 5-client instance for the non-power-of-two wrap.
module tb_mcif_read_ig_wrr_arb;

  localparam int unsigned NC  = 4;
  localparam int unsigned NC5 = 5;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 4;
  localparam int unsigned IW  = 8;
  localparam int unsigned WW  = 8;
  localparam int unsigned OW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [NC-1:0]    req_valid, req_ready;
  logic [NC*AW-1:0] req_addr;
  logic [NC*LW-1:0] req_len;
  logic [NC*WW-1:0] weight;
  logic [OW-1:0]    os_lim;
  logic             eg;
  logic             arvalid, arready;
  logic [IW-1:0]    arid;
  logic [LW-1:0]    arlen;
  logic [AW-1:0]    araddr;

  logic [NC5-1:0]    b_valid, b_ready;
  logic [NC5*AW-1:0] b_addr;
  logic [NC5*LW-1:0] b_len;
  logic [NC5*WW-1:0] b_weight;
  logic [OW-1:0]     b_lim;
  logic              b_eg;
  logic              b_arvalid, b_arready;
  logic [IW-1:0]     b_arid;
  logic [LW-1:0]     b_arlen;
  logic [AW-1:0]     b_araddr;

  mcif_read_ig_wrr_arb #(
    .NUM_CLIENTS (NC), .ADDR_W (AW), .LEN_W (LW), .ID_W (IW), .WEIGHT_W (WW), .OS_W (OW)
  ) dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rst          (rst),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_addr                (req_addr),
    .req_len                 (req_len),
    .reg2dp_rd_weight        (weight),
    .reg2dp_rd_os_cnt        (os_lim),
    .eg2ig_axi_vld           (eg),
    .mcif2noc_axi_ar_arvalid (arvalid),
    .mcif2noc_axi_ar_arready (arready),
    .mcif2noc_axi_ar_arid    (arid),
    .mcif2noc_axi_ar_arlen   (arlen),
    .mcif2noc_axi_ar_araddr  (araddr)
  );

  mcif_read_ig_wrr_arb #(
    .NUM_CLIENTS (NC5), .ADDR_W (AW), .LEN_W (LW), .ID_W (IW), .WEIGHT_W (WW), .OS_W (OW)
  ) dut5 (
    .nvdla_core_clk          (clk),
    .nvdla_core_rst          (rst),
    .req_valid               (b_valid),
    .req_ready               (b_ready),
    .req_addr                (b_addr),
    .req_len                 (b_len),
    .reg2dp_rd_weight        (b_weight),
    .reg2dp_rd_os_cnt        (b_lim),
    .eg2ig_axi_vld           (b_eg),
    .mcif2noc_axi_ar_arvalid (b_arvalid),
    .mcif2noc_axi_ar_arready (b_arready),
    .mcif2noc_axi_ar_arid    (b_arid),
    .mcif2noc_axi_ar_arlen   (b_arlen),
    .mcif2noc_axi_ar_araddr  (b_araddr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'hA000_0000 + 32'(i * 256);
  endfunction

  int exp_id [8] = '{0, 0, 0, 3, 0, 0, 0, 3};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_len   = '0;
    weight    = '0;
    weight[0*WW +: WW] = 8'd2;
    os_lim    = 8'd255;
    eg        = 1'b0;
    arready   = 1'b1;
    b_valid   = '0;
    b_len     = '0;
    b_weight  = '0;
    b_lim     = 8'd255;
    b_eg      = 1'b0;
    b_arready = 1'b1;
    for (int i = 0; i < NC; i++) req_addr[i*AW +: AW] = addr_of(i);
    for (int i = 0; i < NC5; i++) b_addr[i*AW +: AW] = addr_of(i);

    // Reset state
    step();
    step();
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_arid", 64'(arid), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_os", 64'(dut.os_cnt_q), 64'd0);
    check("rst_owner", 64'(dut.owner_q), 64'd0);

    // WRR: clients 0 (w=2) and 3 (w=0)
    rst       = 1'b0;
    req_valid = 4'b1001;
    #1;
    check("wrr_first_ready", 64'(req_ready), 64'b0001);
    for (int k = 0; k < 8; k++) begin
      step();
      check("wrr_arvalid", 64'(arvalid), 64'd1);
      check("wrr_arid", 64'(arid), 64'(exp_id[k]));
    end
    check("wrr_os", 64'(dut.os_cnt_q), 64'd8);
    req_valid = '0;
    step();
    check("idle_arvalid", 64'(arvalid), 64'd0);

    // Credit limit: limit 7 (8 beats), client 1 bursts of 4
    rst = 1'b1;
    step();
    rst = 1'b0;
    os_lim = 8'd7;
    req_len[1*LW +: LW] = 4'd3;
    req_valid = 4'b0010;
    step();
    check("credit_ar1_id", 64'(arid), 64'd1);
    check("credit_ar1_len", 64'(arlen), 64'd3);
    check("credit_ar1_os", 64'(dut.os_cnt_q), 64'd4);
    step();
    check("credit_ar2_vld", 64'(arvalid), 64'd1);
    check("credit_ar2_os", 64'(dut.os_cnt_q), 64'd8);
    #1;
    check("credit_block_ready", 64'(req_ready), 64'd0);
    step();
    check("credit_block_arvalid", 64'(arvalid), 64'd0);
    eg = 1'b1;
    step();
    eg = 1'b0;
    #1;
    check("credit_one_ret_os", 64'(dut.os_cnt_q), 64'd7);
    check("credit_one_ret_ready", 64'(req_ready), 64'd0);
    eg = 1'b1;
    step();
    step();
    step();
    eg = 1'b0;
    #1;
    check("credit_four_ret_os", 64'(dut.os_cnt_q), 64'd4);
    check("credit_four_ret_ready", 64'(req_ready), 64'b0010);
    step();
    check("credit_ar3_vld", 64'(arvalid), 64'd1);
    check("credit_ar3_id", 64'(arid), 64'd1);
    check("credit_ar3_os", 64'(dut.os_cnt_q), 64'd8);

    // Back-pressure: stall 5 cycles, then release with client 2 waiting
    arready   = 1'b0;
    os_lim    = 8'd255;
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_arvalid", 64'(arvalid), 64'd1);
      check("bp_araddr", 64'(araddr), 64'(addr_of(1)));
      check("bp_arid", 64'(arid), 64'd1);
      check("bp_arlen", 64'(arlen), 64'd3);
      check("bp_ready", 64'(req_ready), 64'd0);
    end
    arready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'b0100);
    step();
    check("bp_next_arvalid", 64'(arvalid), 64'd1);
    check("bp_next_arid", 64'(arid), 64'd2);
    check("bp_next_araddr", 64'(araddr), 64'(addr_of(2)));
    check("bp_next_os", 64'(dut.os_cnt_q), 64'd9);

    // Grant coinciding with a return leaves the count unchanged
    req_valid = '0;
    eg = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("net_pre_os", 64'(dut.os_cnt_q), 64'd4);
    req_valid = 4'b0001;
    step();
    eg = 1'b0;
    check("net_arid", 64'(arid), 64'd0);
    check("net_os", 64'(dut.os_cnt_q), 64'd4);

    // Reset mid-transaction
    req_len[0*LW +: LW] = 4'd1;
    step();
    check("mid_arlen", 64'(arlen), 64'd1);
    check("mid_os", 64'(dut.os_cnt_q), 64'd6);
    req_valid = '0;
    arready   = 1'b0;
    step();
    check("mid_stall_arvalid", 64'(arvalid), 64'd1);
    rst = 1'b1;
    step();
    check("mid_rst_arvalid", 64'(arvalid), 64'd0);
    check("mid_rst_os", 64'(dut.os_cnt_q), 64'd0);
    check("mid_rst_owner", 64'(dut.owner_q), 64'd0);
    rst       = 1'b0;
    arready   = 1'b1;
    req_len   = '0;
    weight    = '0;
    req_valid = 4'b1001;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'b0001);
    step();
    check("post_rst_arid0", 64'(arid), 64'd0);
    step();
    check("post_rst_arid3", 64'(arid), 64'd3);
    req_valid = '0;

    // Five clients: owner 4 exhausted, candidates {1,4} -> wrap to 1
    b_valid = 5'b10000;
    step();
    check("wrap_first_arid", 64'(b_arid), 64'd4);
    b_valid = 5'b10010;
    #1;
    check("wrap_ready", 64'(b_ready), 64'b00010);
    step();
    check("wrap_arvalid", 64'(b_arvalid), 64'd1);
    check("wrap_arid", 64'(b_arid), 64'd1);
    b_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
